mac_pipe: RTL and testbench
===========================

# mac_pipe

Parametrised pipelined multiply-accumulate block for iCE40 DSP inference tests. It generalises the single registered multiplier with:
- a configurable input and product register depth;
- signed/unsigned operands;
- a running accumulator with per-sample clear;
- optional saturation and a sticky overflow flag;
- a valid/clock-enable pipeline.

It sits as a top-level test design so synthesis can map its stages onto SB_MAC16 input, pipeline and accumulator registers.

## Interface
- AW, 8, width of operand A
- BW, 8, width of operand B
- ACCW, 32, accumulator/output width; elaboration error if ACCW < AW+BW
- IREG, 1, 0/1: register stage on A, B and sideband
- MREG, 1, 0/1: register stage on product
- SIGNED, 0, 1: two's-complement operands and accumulator; 0: unsigned
- SAT, 0, 1: saturate accumulator at limits; 0: wrap
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous reset, active-high
- ce  input  1  global clock enable; 0 freezes every stage
- in_valid  input  1  A/B/sideband valid this cycle
- A  input  AW  operand A
- B  input  BW  operand B
- acc_clr  input  1  this sample starts a new sum (P := product)
- acc_en  input  1  1: accumulate; 0: P := product (plain multiply)
- out_valid  output  1  P updated on the previous edge
- P  output  ACCW  accumulator / product result
- ovf  output  1  sticky overflow/saturation flag

## Operation
- Sample = {A, B, acc_clr, acc_en, in_valid}; it travels as one word through the pipeline.
- Stages, in order: input (if IREG) -> multiply -> product register (if MREG) -> accumulator (always registered).
- Product width is AW+BW. Extend it to ACCW: sign-extend if SIGNED, zero-extend otherwise.
- Accumulator update on a valid sample at its stage:
  - acc_clr=1 or acc_en=0: P <= ext(product) and ovf <= 0.
  - otherwise: P <= P + ext(product).
- Overflow:
  - SIGNED: operand signs equal and result sign differs.
  - unsigned: carry out of ACCW.
- On overflow:
  - SAT=1: P clamps to max (or min, for negative signed overflow).
  - SAT=0: P wraps.
  - ovf <= 1 in both cases; it stays set until the next clear/non-accumulate sample.
- Invalid samples (valid bit 0) leave P and ovf unchanged.
- out_valid is the accumulator-stage valid bit, registered.

## Timing
- Latency from in_valid to out_valid is L = IREG + MREG + 1 cycles of ce=1.
- Throughput: one sample per cycle.
- ce=0: every register, including the valid bits, P, ovf and out_valid, holds. Inputs are ignored that cycle.
- rst asserted: all stages, P, ovf and out_valid clear to 0 asynchronously. In-flight samples are discarded.
- Reset release: the first sample presented on a ce=1 edge appears L cycles later.
- acc_clr and acc_en are sampled with A and B. They are ignored when in_valid=0.
- Simultaneous clear and overflow: clear wins, so P = ext(product) and ovf = 0.
- IREG=0 and MREG=0: the accumulator stage registers A*B directly and L=1.

## Structure
- Package mac_pkg holds:
  - sat_max/sat_min helper functions, parametrised by ACCW and SIGNED;
  - the sample-word field layout as localparams.
- Sub-module mac_stage: an optional register (bypass when its enable parameter is 0), with ce and async rst, carrying data plus the valid bit. It is instantiated for the input and product stages.
- The accumulator and overflow logic live in mac_pipe.

## Test plan
- Defaults, unsigned. Scenario: A=3, B=5, acc_en=0, one valid. Required: out_valid high exactly 3 cycles later, with P=15 and ovf=0.
- Accumulate. Scenario: acc_clr=1 with (2,4), then acc_en=1 with (3,3) and (1,7). Required: P sequence 8, 17, 24 on consecutive cycles.
- SIGNED=1, ACCW=16, SAT=1. Scenario: repeatedly accumulate (127,127). Required: P climbs 16129 -> 32767 (clamped), ovf=1. A following acc_clr sample with (-2,3) gives P=-6, ovf=0.
- SIGNED=0, ACCW=16, SAT=0. Scenario: accumulate (255,255) twice. Required: second P = 130050 mod 65536 = 64514, ovf=1.
- ce stall. Scenario: drop ce for 4 cycles mid-stream. Required: P, out_valid and pipeline contents hold. Results resume unchanged, and total latency is extended by exactly 4.
- Reset mid-operation. Scenario: assert rst with 2 samples in flight. Required: P=0 and out_valid=0 immediately, with no stale outputs after release. Also run the IREG=0, MREG=0 variant and check L=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC pipeline: sample-word field layout and saturation limits.
// Pure constants and constant functions; no timing or flow control of their own.
package mac_pkg;

    localparam int SMP_EN_BIT  = 0;
    localparam int SMP_CLR_BIT = 1;
    localparam int SMP_CTL_W   = 2;
    localparam int SAT_FN_W    = 64;

    function automatic logic [SAT_FN_W-1:0] sat_max(input int accw, input bit is_signed);
        logic [SAT_FN_W-1:0] r;
        r = {SAT_FN_W{1'b1}} >> (SAT_FN_W - accw);
        if (is_signed) begin
            r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [SAT_FN_W-1:0] sat_min(input int accw, input bit is_signed);
        logic [SAT_FN_W-1:0] r;
        r = '0;
        if (is_signed) begin
            r = {{(SAT_FN_W-1){1'b0}}, 1'b1} << (accw - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_stage.sv
// Optional pipeline register for data plus valid; latency EN cycles (0 = combinational bypass).
// No backpressure: ce=0 freezes the register, rst clears it asynchronously.
module mac_stage #(
    parameter int W  = 1,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    generate
        if (EN) begin : g_reg
            logic         vld_q, vld_d;
            logic [W-1:0] dat_q, dat_d;

            always_comb begin
                vld_d = vld_q;
                dat_d = dat_q;
                if (ce) begin
                    vld_d = in_vld;
                    dat_d = in_dat;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end

            assign out_vld = vld_q;
            assign out_dat = dat_q;
        end else begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, ce};
            assign out_vld   = in_vld;
            assign out_dat   = in_dat;
        end
    endgenerate

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate with optional input/product registers, saturation and sticky overflow.
// Latency IREG+MREG+1 ce cycles, one sample per cycle; no backpressure, ce=0 freezes every stage.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int AW     = 8,
    parameter int BW     = 8,
    parameter int ACCW   = 32,
    parameter int IREG   = 1,
    parameter int MREG   = 1,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            in_valid,
    input  logic [AW-1:0]   A,
    input  logic [BW-1:0]   B,
    input  logic            acc_clr,
    input  logic            acc_en,
    output logic            out_valid,
    output logic [ACCW-1:0] P,
    output logic            ovf
);

    localparam int PW = AW + BW;
    localparam int IW = PW + SMP_CTL_W;
    localparam int MW = PW + SMP_CTL_W;
    localparam logic [SAT_FN_W-1:0] MAX_FULL = sat_max(ACCW, SIGNED != 0);
    localparam logic [SAT_FN_W-1:0] MIN_FULL = sat_min(ACCW, SIGNED != 0);
    localparam logic [ACCW-1:0]     MAX_V    = MAX_FULL[ACCW-1:0];
    localparam logic [ACCW-1:0]     MIN_V    = MIN_FULL[ACCW-1:0];

    generate
        if (ACCW < PW) begin : g_bad_accw
            $error("mac_pipe: ACCW must be at least AW+BW");
        end
        if (ACCW > SAT_FN_W) begin : g_wide_accw
            $error("mac_pipe: ACCW exceeds saturation helper width");
        end
    endgenerate

    logic          s1_vld, m_vld;
    logic [IW-1:0] s1_dat;
    logic [MW-1:0] m_dat;
    logic [AW-1:0] a_s;
    logic [BW-1:0] b_s;
    logic [PW-1:0] a_ext, b_ext, prod, m_prod;
    logic          m_clr, m_en;

    mac_stage #(.W(IW), .EN(IREG != 0)) u_in_stage (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .in_vld  (in_valid),
        .in_dat  ({A, B, acc_clr, acc_en}),
        .out_vld (s1_vld),
        .out_dat (s1_dat)
    );

    assign a_s = s1_dat[IW-1 -: AW];
    assign b_s = s1_dat[SMP_CTL_W +: BW];

    // Low PW bits of the extended product are exact for both signed and unsigned operands.
    always_comb begin
        a_ext = {{BW{1'b0}}, a_s};
        b_ext = {{AW{1'b0}}, b_s};
        if (SIGNED != 0) begin
            a_ext = {{BW{a_s[AW-1]}}, a_s};
            b_ext = {{AW{b_s[BW-1]}}, b_s};
        end
        prod = a_ext * b_ext;
    end

    mac_stage #(.W(MW), .EN(MREG != 0)) u_mul_stage (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .in_vld  (s1_vld),
        .in_dat  ({prod, s1_dat[SMP_CTL_W-1:0]}),
        .out_vld (m_vld),
        .out_dat (m_dat)
    );

    assign m_prod = m_dat[MW-1 -: PW];
    assign m_clr  = m_dat[SMP_CLR_BIT];
    assign m_en   = m_dat[SMP_EN_BIT];

    logic [ACCW-1:0] ext, p_q, p_d;
    logic [ACCW:0]   sum;
    logic            of_det, ovf_q, ovf_d, out_valid_q, out_valid_d;

    assign ext = (SIGNED != 0) ? ACCW'($signed(m_prod)) : ACCW'(m_prod);

    always_comb begin
        sum = {1'b0, p_q} + {1'b0, ext};
        if (SIGNED != 0) begin
            of_det = (p_q[ACCW-1] == ext[ACCW-1]) && (sum[ACCW-1] != p_q[ACCW-1]);
        end else begin
            of_det = sum[ACCW];
        end
        p_d         = p_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = m_vld;
            if (m_vld) begin
                if (m_clr || !m_en) begin
                    p_d   = ext;
                    ovf_d = 1'b0;
                end else begin
                    p_d = sum[ACCW-1:0];
                    if (of_det) begin
                        ovf_d = 1'b1;
                        // Signed overflow with a negative running sum can only go below min.
                        if (SAT != 0) begin
                            p_d = ((SIGNED != 0) && p_q[ACCW-1]) ? MIN_V : MAX_V;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: default, signed-saturating, unsigned-wrapping and zero-register variants.
module tb_mac_pipe;

    logic       clk = 1'b0;
    logic       rst, ce, in_valid, acc_clr, acc_en;
    logic [7:0] a, b;

    logic        d_vld, d_ovf;
    logic [31:0] d_p;
    logic        s_vld, s_ovf;
    logic [15:0] s_p;
    logic        u_vld, u_ovf;
    logic [15:0] u_p;
    logic        z_vld, z_ovf;
    logic [31:0] z_p;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_pipe u_def (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .A(a), .B(b),
        .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(d_vld), .P(d_p), .ovf(d_ovf)
    );

    mac_pipe #(.ACCW(16), .SIGNED(1), .SAT(1)) u_s16 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .A(a), .B(b),
        .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(s_vld), .P(s_p), .ovf(s_ovf)
    );

    mac_pipe #(.ACCW(16), .SIGNED(0), .SAT(0)) u_u16 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .A(a), .B(b),
        .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(u_vld), .P(u_p), .ovf(u_ovf)
    );

    mac_pipe #(.IREG(0), .MREG(0)) u_l1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .A(a), .B(b),
        .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(z_vld), .P(z_p), .ovf(z_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                         input logic c, input logic e);
        in_valid = v;
        a        = xa;
        b        = xb;
        acc_clr  = c;
        acc_en   = e;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ce  = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        #3;
        checks++;
        if ({d_vld, d_ovf, d_p} !== 34'd0) begin
            failures++;
            $display("FAIL reset_def: got vld=%b ovf=%b P=%0d, want 0 0 0", d_vld, d_ovf, d_p);
        end
        checks++;
        if ({s_vld, s_ovf, s_p, u_vld, u_ovf, u_p, z_vld, z_ovf, z_p} !== 70'd0) begin
            failures++;
            $display("FAIL reset_variants: got s_p=%0d u_p=%0d z_p=%0d, want all zero", s_p, u_p, z_p);
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_unsigned_mul;
        drive(1'b1, 8'd3, 8'd5, 1'b0, 1'b0);
        tick;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (d_vld !== 1'b0) begin
                failures++;
                $display("FAIL mul_early_valid: edge %0d got out_valid=%b, want 0", i, d_vld);
            end
            tick;
        end
        checks++;
        if (d_vld !== 1'b1 || d_p !== 32'd15 || d_ovf !== 1'b0) begin
            failures++;
            $display("FAIL mul_result: got vld=%b P=%0d ovf=%b, want 1 15 0", d_vld, d_p, d_ovf);
        end
        tick;
        checks++;
        if (d_vld !== 1'b0 || d_p !== 32'd15) begin
            failures++;
            $display("FAIL mul_single_pulse: got vld=%b P=%0d, want 0 15", d_vld, d_p);
        end
    endtask

    task automatic test_accumulate;
        logic [31:0] exp_p [3];
        exp_p[0] = 32'd8;
        exp_p[1] = 32'd17;
        exp_p[2] = 32'd24;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(1'b1, 8'd2, 8'd4, 1'b1, 1'b1);
                1:       drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1);
                2:       drive(1'b1, 8'd1, 8'd7, 1'b0, 1'b1);
                default: drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            endcase
            tick;
            if (i >= 2) begin
                checks++;
                if (d_vld !== 1'b1 || d_p !== exp_p[i-2] || d_ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL accumulate[%0d]: got vld=%b P=%0d ovf=%b, want 1 %0d 0",
                             i - 2, d_vld, d_p, d_ovf, exp_p[i-2]);
                end
            end
        end
    endtask

    task automatic test_signed_sat;
        logic [15:0] exp_p [5];
        logic        exp_o [5];
        exp_p[0] = 16'd16129; exp_o[0] = 1'b0;
        exp_p[1] = 16'd32258; exp_o[1] = 1'b0;
        exp_p[2] = 16'd32767; exp_o[2] = 1'b1;
        exp_p[3] = 16'd32767; exp_o[3] = 1'b1;
        exp_p[4] = 16'hFFFA;  exp_o[4] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b1);
            else if (i < 4)  drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b1);
            else if (i == 4) drive(1'b1, 8'hFE, 8'd3, 1'b1, 1'b1);
            else             drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            tick;
            if (i >= 2) begin
                checks++;
                if (s_vld !== 1'b1 || s_p !== exp_p[i-2] || s_ovf !== exp_o[i-2]) begin
                    failures++;
                    $display("FAIL signed_sat[%0d]: got vld=%b P=%h ovf=%b, want 1 %h %b",
                             i - 2, s_vld, s_p, s_ovf, exp_p[i-2], exp_o[i-2]);
                end
            end
        end
    endtask

    task automatic test_unsigned_wrap;
        logic [15:0] exp_p [2];
        logic        exp_o [2];
        exp_p[0] = 16'd65025; exp_o[0] = 1'b0;
        exp_p[1] = 16'd64514; exp_o[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      drive(1'b1, 8'd255, 8'd255, 1'b1, 1'b1);
            else if (i == 1) drive(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
            else             drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            tick;
            if (i >= 2) begin
                checks++;
                if (u_vld !== 1'b1 || u_p !== exp_p[i-2] || u_ovf !== exp_o[i-2]) begin
                    failures++;
                    $display("FAIL unsigned_wrap[%0d]: got vld=%b P=%0d ovf=%b, want 1 %0d %b",
                             i - 2, u_vld, u_p, u_ovf, exp_p[i-2], exp_o[i-2]);
                end
            end
        end
    endtask

    task automatic test_ce_stall;
        drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b1);
        tick;
        drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b1);
        tick;
        drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1);
        tick;
        checks++;
        if (d_vld !== 1'b1 || d_p !== 32'd1) begin
            failures++;
            $display("FAIL stall_pre: got vld=%b P=%0d, want 1 1", d_vld, d_p);
        end
        ce = 1'b0;
        drive(1'b1, 8'd9, 8'd9, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (d_vld !== 1'b1 || d_p !== 32'd1 || d_ovf !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got vld=%b P=%0d ovf=%b, want 1 1 0", i, d_vld, d_p, d_ovf);
            end
        end
        ce = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick;
        checks++;
        if (d_vld !== 1'b1 || d_p !== 32'd5) begin
            failures++;
            $display("FAIL stall_resume1: got vld=%b P=%0d, want 1 5", d_vld, d_p);
        end
        tick;
        checks++;
        if (d_vld !== 1'b1 || d_p !== 32'd14) begin
            failures++;
            $display("FAIL stall_resume2: got vld=%b P=%0d, want 1 14", d_vld, d_p);
        end
        tick;
        checks++;
        if (d_vld !== 1'b0 || d_p !== 32'd14) begin
            failures++;
            $display("FAIL stall_drain: got vld=%b P=%0d, want 0 14", d_vld, d_p);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 8'd4, 8'd4, 1'b1, 1'b1);
        tick;
        drive(1'b1, 8'd5, 8'd5, 1'b1, 1'b1);
        tick;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (d_vld !== 1'b0 || d_p !== 32'd0 || d_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_immediate: got vld=%b P=%0d ovf=%b, want 0 0 0", d_vld, d_p, d_ovf);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (d_vld !== 1'b0 || d_p !== 32'd0) begin
                failures++;
                $display("FAIL reset_mid_stale[%0d]: got vld=%b P=%0d, want 0 0", i, d_vld, d_p);
            end
        end
    endtask

    task automatic test_zero_regs;
        drive(1'b1, 8'd6, 8'd7, 1'b0, 1'b0);
        tick;
        checks++;
        if (z_vld !== 1'b1 || z_p !== 32'd42) begin
            failures++;
            $display("FAIL l1_latency: got vld=%b P=%0d, want 1 42", z_vld, z_p);
        end
        drive(1'b1, 8'd2, 8'd3, 1'b1, 1'b1);
        tick;
        drive(1'b1, 8'd4, 8'd5, 1'b0, 1'b1);
        tick;
        checks++;
        if (z_vld !== 1'b1 || z_p !== 32'd26) begin
            failures++;
            $display("FAIL l1_back_to_back: got vld=%b P=%0d, want 1 26", z_vld, z_p);
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick;
        checks++;
        if (z_vld !== 1'b0 || z_p !== 32'd26) begin
            failures++;
            $display("FAIL l1_idle: got vld=%b P=%0d, want 0 26", z_vld, z_p);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_mul;
        test_accumulate;
        test_signed_sat;
        test_unsigned_wrap;
        test_ce_stall;
        test_reset_mid;
        test_zero_regs;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
